// File: rtl/osc_cal_pkg.sv
// Shared definitions for the ring-oscillator calibration sequencer:
// the FSM state encoding, default widths and the synchronizer depth.
package osc_cal_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_MEASURE,
        ST_EVAL,
        ST_APPLY
    } cal_state_e;

    localparam int DEF_SEL_W  = 4;
    localparam int DEF_CNT_W  = 10;
    localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/osc_edge_counter.sv
// Counts rising edges of the asynchronous oscillator output: a SYNC_DEPTH-flop
// synchronizer, one extra flop for edge detection, and a saturating counter.
module osc_edge_counter
    import osc_cal_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             i_osc,
    input  logic             i_clear,
    input  logic             i_cnt_en,
    output logic [CNT_W-1:0] o_count
);

    logic [SYNC_DEPTH:0] r_sync;
    logic [CNT_W-1:0]    r_count;
    logic                w_rise;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_DEPTH-1:0], i_osc};
        end
    end

    // Last synchronized stage high while the detection flop is still low.
    assign w_rise = r_sync[SYNC_DEPTH-1] & ~r_sync[SYNC_DEPTH];

    always_ff @(posedge clk) begin
        if (srst || i_clear) begin
            r_count <= '0;
        end else if (i_cnt_en && w_rise && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/ring_osc_cal_ctrl.sv
// Ring-oscillator calibration: sweeps all select codes, keeps the one whose edge
// count is closest to the target, then applies it. CAL_EARLY_EXIT_EN stops on an exact hit.
module ring_osc_cal_ctrl
    import osc_cal_pkg::*;
#(
    parameter int SEL_W      = DEF_SEL_W,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int SETTLE_CYC = 16,
    parameter int WINDOW_CYC = 1000
) (
    input  logic             fpga_clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] target_i,
    input  logic             osc_i,
    output logic             enable_o,
    output logic [SEL_W-1:0] freq_sel_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [SEL_W-1:0] best_sel_o,
    output logic [CNT_W-1:0] best_count_o
);

    localparam int MAX_CYC = (SETTLE_CYC > WINDOW_CYC) ? SETTLE_CYC : WINDOW_CYC;
    localparam int TMR_W   = $clog2(MAX_CYC + 1);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW_CYC - 1);

    cal_state_e       r_state;
    cal_state_e       w_state_next;
    logic [TMR_W-1:0] r_timer;
    logic [SEL_W-1:0] r_sel;
    logic [CNT_W-1:0] r_target;
    logic             r_best_valid;
    logic [SEL_W-1:0] r_best_sel;
    logic [CNT_W-1:0] r_best_count;
    logic [CNT_W:0]   r_best_diff;
    logic             r_enable;
    logic [SEL_W-1:0] r_freq_sel;
    logic [SEL_W-1:0] r_best_sel_out;
    logic [CNT_W-1:0] r_best_count_out;

    logic [CNT_W-1:0] w_count;
    logic [CNT_W:0]   w_count_ext;
    logic [CNT_W:0]   w_target_ext;
    logic [CNT_W:0]   w_diff;
    logic             w_take;
    logic             w_last_code;
    logic             w_exit;
    logic             w_timer_done;
    logic [SEL_W-1:0] w_win_sel;
    logic [CNT_W-1:0] w_win_count;
    logic             w_cnt_clear;
    logic             w_cnt_en;

    assign w_cnt_clear = (r_state == ST_SETTLE);
    assign w_cnt_en    = (r_state == ST_MEASURE);

    osc_edge_counter #(
        .CNT_W (CNT_W)
    ) u_edge_counter (
        .clk      (fpga_clk_i),
        .srst     (reset_i),
        .i_osc    (osc_i),
        .i_clear  (w_cnt_clear),
        .i_cnt_en (w_cnt_en),
        .o_count  (w_count)
    );

    assign w_count_ext  = {1'b0, w_count};
    assign w_target_ext = {1'b0, r_target};
    assign w_diff       = (w_count_ext >= w_target_ext) ? (w_count_ext - w_target_ext)
                                                        : (w_target_ext - w_count_ext);
    // Strict compare: on a tie the earlier (lower) code is kept.
    assign w_take       = !r_best_valid || (w_diff < r_best_diff);
    assign w_last_code  = (r_sel == {SEL_W{1'b1}});
    assign w_win_sel    = w_take ? r_sel   : r_best_sel;
    assign w_win_count  = w_take ? w_count : r_best_count;

`ifdef CAL_EARLY_EXIT_EN
    assign w_exit = w_last_code || (w_diff == '0);
`else
    assign w_exit = w_last_code;
`endif

    assign w_timer_done = ((r_state == ST_SETTLE)  && (r_timer == SETTLE_LAST)) ||
                          ((r_state == ST_MEASURE) && (r_timer == WINDOW_LAST));

    always_ff @(posedge fpga_clk_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (start_i)      w_state_next = ST_SETTLE;
            ST_SETTLE:  if (w_timer_done) w_state_next = ST_MEASURE;
            ST_MEASURE: if (w_timer_done) w_state_next = ST_EVAL;
            ST_EVAL:    w_state_next = w_exit ? ST_APPLY : ST_SETTLE;
            ST_APPLY:   w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge fpga_clk_i) begin
        if (reset_i) begin
            r_timer          <= '0;
            r_sel            <= '0;
            r_target         <= '0;
            r_best_valid     <= 1'b0;
            r_best_sel       <= '0;
            r_best_count     <= '0;
            r_best_diff      <= '0;
            r_enable         <= 1'b0;
            r_freq_sel       <= '0;
            r_best_sel_out   <= '0;
            r_best_count_out <= '0;
        end else begin
            if (((r_state == ST_SETTLE) || (r_state == ST_MEASURE)) && !w_timer_done) begin
                r_timer <= r_timer + 1'b1;
            end else begin
                r_timer <= '0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_target     <= target_i;
                        r_sel        <= '0;
                        r_freq_sel   <= '0;
                        r_enable     <= 1'b1;
                        r_best_valid <= 1'b0;
                    end
                end
                ST_EVAL: begin
                    if (w_take) begin
                        r_best_valid <= 1'b1;
                        r_best_sel   <= r_sel;
                        r_best_count <= w_count;
                        r_best_diff  <= w_diff;
                    end
                    // Published results change only when entering APPLY.
                    if (w_exit) begin
                        r_freq_sel       <= w_win_sel;
                        r_best_sel_out   <= w_win_sel;
                        r_best_count_out <= w_win_count;
                    end else begin
                        r_sel      <= r_sel + 1'b1;
                        r_freq_sel <= r_sel + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign enable_o     = r_enable;
    assign freq_sel_o   = r_freq_sel;
    assign busy_o       = (r_state != ST_IDLE);
    assign done_o       = (r_state == ST_APPLY);
    assign best_sel_o   = r_best_sel_out;
    assign best_count_o = r_best_count_out;

endmodule

// File: tb/tb_ring_osc_cal_ctrl.sv
// Directed bench for ring_osc_cal_ctrl: a behavioural oscillator (period 2*(sel+2) clocks)
// feeds the DUT, and recorded samples give the expected per-code edge counts.
module tb_ring_osc_cal_ctrl;

    localparam int SEL_W  = 4;
    localparam int CNT_W  = 10;
    localparam int SETTLE = 4;
    localparam int WINDOW = 64;
    localparam int SLOT   = SETTLE + WINDOW + 1;
    localparam int NCODE  = 1 << SEL_W;
    localparam int HIST   = 4096;

    logic             clk = 1'b0;
    logic             reset_i = 1'b1;
    logic             start_i = 1'b0;
    logic [CNT_W-1:0] target_i = '0;
    logic             osc = 1'b0;
    logic             enable_o;
    logic [SEL_W-1:0] freq_sel_o;
    logic             busy_o;
    logic             done_o;
    logic [SEL_W-1:0] best_sel_o;
    logic [CNT_W-1:0] best_count_o;

    logic             start_s = 1'b0;
    logic [2:0]       target_s = '0;
    logic             osc_s = 1'b0;
    logic             s_enable;
    logic [SEL_W-1:0] s_freq_sel;
    logic             s_busy;
    logic             s_done;
    logic [SEL_W-1:0] s_best_sel;
    logic [2:0]       s_best_count;

    always #5 clk = ~clk;

    ring_osc_cal_ctrl #(
        .SEL_W(SEL_W), .CNT_W(CNT_W), .SETTLE_CYC(SETTLE), .WINDOW_CYC(WINDOW)
    ) u_dut (
        .fpga_clk_i(clk), .reset_i(reset_i), .start_i(start_i), .target_i(target_i),
        .osc_i(osc), .enable_o(enable_o), .freq_sel_o(freq_sel_o), .busy_o(busy_o),
        .done_o(done_o), .best_sel_o(best_sel_o), .best_count_o(best_count_o)
    );

    ring_osc_cal_ctrl #(
        .SEL_W(SEL_W), .CNT_W(3), .SETTLE_CYC(SETTLE), .WINDOW_CYC(WINDOW)
    ) u_sat (
        .fpga_clk_i(clk), .reset_i(reset_i), .start_i(start_s), .target_i(target_s),
        .osc_i(osc_s), .enable_o(s_enable), .freq_sel_o(s_freq_sel), .busy_o(s_busy),
        .done_o(s_done), .best_sel_o(s_best_sel), .best_count_o(s_best_count)
    );

    // Oscillator models: phase restarts on a code change, half period = sel+2 clocks.
    int ph = 0, last_sel = 0, ph_s = 0, last_sel_s = 0;
    always @(negedge clk) begin
        if (!enable_o) begin
            osc = 1'b0; ph = 0;
        end else if (int'(freq_sel_o) != last_sel) begin
            ph = 0;
        end else begin
            ph++;
            if (ph >= int'(freq_sel_o) + 2) begin osc = ~osc; ph = 0; end
        end
        last_sel = int'(freq_sel_o);
    end
    always @(negedge clk) begin
        if (!s_enable) begin
            osc_s = 1'b0; ph_s = 0;
        end else if (int'(s_freq_sel) != last_sel_s) begin
            ph_s = 0;
        end else begin
            ph_s++;
            if (ph_s >= int'(s_freq_sel) + 2) begin osc_s = ~osc_s; ph_s = 0; end
        end
        last_sel_s = int'(s_freq_sel);
    end

    // samp[n] = oscillator level seen at the posedge that opens cycle n.
    int cyc = 0;
    bit samp [HIST];
    always @(posedge clk) begin
        cyc = cyc + 1;
        samp[cyc % HIST] = osc;
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    typedef struct {
        int target;
        bit extra;
        int exp_sel;
        int exp_cnt;
    } vec_t;

    vec_t vecs [5];

    task automatic run_cal(input int tgt, input bit extra, input int exp_sel, input int exp_cnt);
        int c0, done_cyc, ndone, sel_d, cnt_d, fs_d, en_d, busy_d, busy_after;
        int old_sel, old_cnt, partial_bad, ncode, cnt, diff, bsel, bcnt, bdiff, lo;
        done_cyc = -1; ndone = 0; sel_d = -1; cnt_d = -1; fs_d = -1; en_d = -1; busy_d = -1;
        busy_after = -1; partial_bad = 0;
        @(posedge clk); #1;
        target_i = CNT_W'(tgt); start_i = 1'b1; c0 = cyc;
        old_sel = int'(best_sel_o); old_cnt = int'(best_count_o);
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int i = 0; i < 1300; i++) begin
            @(negedge clk);
            if (extra) start_i = (i == 20 || i == 100 || i == 150);
            if (done_o) begin
                ndone++;
                if (done_cyc < 0) begin
                    done_cyc = cyc; sel_d = int'(best_sel_o); cnt_d = int'(best_count_o);
                    fs_d = int'(freq_sel_o); en_d = int'(enable_o); busy_d = int'(busy_o);
                end
            end else if (done_cyc < 0 &&
                         (int'(best_sel_o) != old_sel || int'(best_count_o) != old_cnt)) begin
                partial_bad = 1;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after = int'(busy_o);
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
        end
        start_i = 1'b0;
        // Expected result from the spec's selection rule applied to observed edges.
        bsel = 0; bcnt = 0; bdiff = 0; ncode = 0;
        for (int k = 0; k < NCODE; k++) begin
            lo = c0 + 1 + k * SLOT + SETTLE;
            cnt = 0;
            for (int n = lo; n < lo + WINDOW; n++)
                if (samp[(n - 1) % HIST] && !samp[(n - 2) % HIST]) cnt++;
            if (cnt > (1 << CNT_W) - 1) cnt = (1 << CNT_W) - 1;
            diff = (cnt >= tgt) ? cnt - tgt : tgt - cnt;
            if (k == 0 || diff < bdiff) begin bsel = k; bcnt = cnt; bdiff = diff; end
            ncode = k + 1;
`ifdef CAL_EARLY_EXIT_EN
            if (diff == 0) break;
`endif
        end
        $display("run target=%0d extra=%0d: done after %0d cycles, best_sel=%0d best_count=%0d (model %0d/%0d)",
                 tgt, extra, done_cyc - c0, sel_d, cnt_d, bsel, bcnt);
        chk("done_latency", done_cyc - c0, 1 + ncode * SLOT);
        chk("done_pulses", ndone, 1);
        chk("best_sel", sel_d, bsel);
        chk("best_count", cnt_d, bcnt);
        chk("apply_freq_sel", fs_d, bsel);
        chk("apply_enable", en_d, 1);
        chk("apply_busy", busy_d, 1);
        chk("busy_after_apply", busy_after, 0);
        chk("no_partial_result", partial_bad, 0);
        chk("idle_hold_freq_sel", int'(freq_sel_o), bsel);
        chk("idle_hold_enable", int'(enable_o), 1);
        if (exp_sel >= 0) begin
            chk("hand_best_sel", sel_d, exp_sel);
            chk("hand_best_count", cnt_d, exp_cnt);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int found, c0, dcyc;
        vecs[0] = '{target: 8,    extra: 1'b0, exp_sel: 2,  exp_cnt: 8};   // nominal
        vecs[1] = '{target: 9,    extra: 1'b0, exp_sel: -1, exp_cnt: -1};  // tie sel1 vs sel2
        vecs[2] = '{target: 0,    extra: 1'b0, exp_sel: -1, exp_cnt: -1};  // lowest count wins
        vecs[3] = '{target: 1023, extra: 1'b0, exp_sel: 0,  exp_cnt: 16};  // highest count wins
        vecs[4] = '{target: 8,    extra: 1'b1, exp_sel: 2,  exp_cnt: 8};   // starts while busy

        repeat (3) @(posedge clk);
        #1 reset_i = 1'b0;
        @(negedge clk);
        chk("rst_enable", int'(enable_o), 0);
        chk("rst_freq_sel", int'(freq_sel_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_best_sel", int'(best_sel_o), 0);
        chk("rst_best_count", int'(best_count_o), 0);

        for (int v = 0; v < 5; v++)
            run_cal(vecs[v].target, vecs[v].extra, vecs[v].exp_sel, vecs[v].exp_cnt);

        // Reset in the middle of the sel=5 measurement window.
        @(posedge clk); #1;
        target_i = 10'd3; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        found = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (freq_sel_o == 4'd5) begin found = 1; break; end
        end
        chk("reach_sel5", found, 1);
        repeat (10) @(negedge clk);
        reset_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        $display("mid-sweep reset: enable=%0d freq_sel=%0d busy=%0d", enable_o, freq_sel_o, busy_o);
        chk("midrst_enable", int'(enable_o), 0);
        chk("midrst_freq_sel", int'(freq_sel_o), 0);
        chk("midrst_busy", int'(busy_o), 0);
        chk("midrst_done", int'(done_o), 0);
        chk("midrst_best_sel", int'(best_sel_o), 0);
        chk("midrst_best_count", int'(best_count_o), 0);
        reset_i = 1'b0;
        run_cal(8, 1'b0, 2, 8);

        // Saturation: CNT_W=3, every fast code clips to 7, the lowest code wins.
        @(posedge clk); #1;
        target_s = 3'd7; start_s = 1'b1; c0 = cyc;
        @(posedge clk); #1;
        start_s = 1'b0;
        dcyc = -1;
        for (int i = 0; i < 1300; i++) begin
            @(negedge clk);
            if (s_done) begin dcyc = cyc; break; end
        end
        $display("saturation run: done after %0d cycles, best_sel=%0d best_count=%0d",
                 dcyc - c0, s_best_sel, s_best_count);
`ifdef CAL_EARLY_EXIT_EN
        chk("sat_latency", dcyc - c0, 1 + SLOT);
`else
        chk("sat_latency", dcyc - c0, 1 + NCODE * SLOT);
`endif
        chk("sat_best_sel", int'(s_best_sel), 0);
        chk("sat_best_count", int'(s_best_count), 7);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
